fx_chain_ctrl: RTL and testbench

Parametrised effect-chain controller for the guitar pedal datapath: routes the codec's left sample through `N_FX` serially connected effect cores, each individually bypassable.
- A slider selects which effect is armed; a debounced push-button toggles that effect on or off.
- On/off transitions crossfade over a programmable number of samples instead of switching hard, so toggling produces no clicks.
- Sits between the codec interface, the effect cores and the board LEDs, and generalises the fixed four-effect selector to any effect count.

---
 rtl/fx_chain_ctrl.sv | 125 ++++++++++++
 tb/tb_fx_chain_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_chain_ctrl.sv
// fx_chain_ctrl: serial chain of N_FX bypassable effect stages with debounced slider selection.
// Define FX_XFADE_EN for per-sample gain ramps; left undefined, gains switch hard on the next VALID.
`default_nettype none

module fx_chain_ctrl #(
  parameter int N_FX       = 4,
  parameter int W          = 16,
  parameter int RAMP_BITS  = 6,
  parameter int STABLE_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic                         VALID,
  input  logic signed [W-1:0]          dry_in,
  input  logic [N_FX*W-1:0]            fx_out,
  input  logic [11:0]                  sel_pot,
  input  logic                         pb_fall,
  output logic [N_FX*W-1:0]            fx_in,
  output logic signed [W-1:0]          chain_out,
  output logic [N_FX-1:0]              fx_on,
  output logic [$clog2(N_FX+1)-1:0]    sel,
  output logic [2*N_FX-1:0]            LED
);

  localparam int SEL_W = $clog2(N_FX + 1);
  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int P     = W + RAMP_BITS + 2;
  localparam logic [RAMP_BITS:0] FULL = {1'b1, {RAMP_BITS{1'b0}}};

  logic [15:0]        zone_prod;
  logic [SEL_W-1:0]   zone;
  logic [SEL_W-1:0]   cand;
  logic [CNT_W-1:0]   cnt;
  logic [RAMP_BITS:0] g [N_FX];
  logic signed [W-1:0] s [N_FX];

  assign zone_prod = {4'b0, sel_pot} * 16'(N_FX + 1);
  assign zone      = SEL_W'(zone_prod >> 12);

  // sel commits on the edge after the counter reaches STABLE_CYC-1, even if the zone moves on that edge
  always_ff @(posedge clk) begin
    if (RESET) begin
      cand <= '0;
      cnt  <= '0;
      sel  <= '0;
    end else begin
      if (cnt == CNT_W'(STABLE_CYC - 1))
        sel <= cand;
      if (zone != cand) begin
        cand <= zone;
        cnt  <= '0;
      end else if (cnt != CNT_W'(STABLE_CYC)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      fx_on <= '0;
    end else begin
      for (int k = 0; k < N_FX; k++)
        if (pb_fall && sel == SEL_W'(k + 1))
          fx_on[k] <= ~fx_on[k];
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int k = 0; k < N_FX; k++)
        g[k] <= '0;
    end else if (VALID) begin
      for (int k = 0; k < N_FX; k++) begin
`ifdef FX_XFADE_EN
        if (fx_on[k] && g[k] != FULL)
          g[k] <= g[k] + 1'b1;
        else if (!fx_on[k] && g[k] != '0)
          g[k] <= g[k] - 1'b1;
`else
        g[k] <= fx_on[k] ? FULL : '0;
`endif
      end
    end
  end

  // Convex mix g*wet + (FULL-g)*dry always lands back inside W bits
  for (genvar k = 0; k < N_FX; k++) begin : g_stage
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [P-1:0] acc;

    if (k == 0) begin : g_head
      assign x = dry_in;
    end else begin : g_link
      assign x = s[k-1];
    end

    assign y   = fx_out[k*W +: W];
    assign acc = $signed({{(P-RAMP_BITS-1){1'b0}}, g[k]}) * P'(y)
               + $signed({{(P-RAMP_BITS-1){1'b0}}, FULL - g[k]}) * P'(x);
    assign s[k] = W'(acc >>> RAMP_BITS);
    assign fx_in[k*W +: W] = x;
  end

  always_ff @(posedge clk) begin
    if (RESET)
      chain_out <= '0;
    else if (VALID)
      chain_out <= s[N_FX-1];
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      LED <= '0;
    end else begin
      for (int k = 0; k < N_FX; k++) begin
        LED[2*k]   <= (sel == SEL_W'(k + 1));
        LED[2*k+1] <= (sel == SEL_W'(k + 1)) && fx_on[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fx_chain_ctrl.sv
// tb_fx_chain_ctrl: randomized and directed stimulus checked against a sample-level reference model.
`default_nettype none

module tb_fx_chain_ctrl;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int RB   = 6;
  localparam int S    = 1024;
  localparam int FULL = 64;
`ifdef FX_XFADE_EN
  localparam bit XF = 1'b1;
`else
  localparam bit XF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                RESET, VALID, pb_fall;
  logic signed [W-1:0] dry_in, chain_out;
  logic [N*W-1:0]      fx_out, fx_in;
  logic [11:0]         sel_pot;
  logic [N-1:0]        fx_on;
  logic [2:0]          sel;
  logic [2*N-1:0]      LED;

  fx_chain_ctrl #(.N_FX(N), .W(W), .RAMP_BITS(RB), .STABLE_CYC(S)) dut (
    .clk(clk), .RESET(RESET), .VALID(VALID), .dry_in(dry_in), .fx_out(fx_out),
    .sel_pot(sel_pot), .pb_fall(pb_fall), .fx_in(fx_in), .chain_out(chain_out),
    .fx_on(fx_on), .sel(sel), .LED(LED)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: gains, targets, selection run-length, expected outputs
  int          g_m [N];
  bit          on_m [N];
  int          sel_m, zs, run, mode;
  logic [15:0] chain_m;
  logic [7:0]  led_m;
  logic [15:0] xs [N+1];
  logic [15:0] cur_dry;
  logic [11:0] cur_pot;

  // Effect cores: mode 0 holds constant outputs, mode 1 applies simple transfer functions
  function automatic logic [15:0] fx_func(input int k, input logic [15:0] x);
    int v;
    int r;
    v = $signed(x);
    if (mode == 0) begin
      case (k)
        0:       r = 'h3000;
        1:       r = 'h0500;
        2:       r = -'h0200;
        default: r = 'h0111;
      endcase
    end else begin
      case (k)
        0:       r = v + 'h100;
        1:       r = v - 'h80;
        2:       r = v * 2;
        default: r = -v;
      endcase
    end
    return 16'(r);
  endfunction

  task automatic drive_fx();
    int a, b;
    logic [15:0] y;
    xs[0] = dry_in;
    for (int k = 0; k < N; k++) begin
      y = fx_func(k, xs[k]);
      fx_out[k*W +: W] = y;
      a = $signed(xs[k]);
      b = $signed(y);
      xs[k+1] = 16'((g_m[k] * b + (FULL - g_m[k]) * a) >>> RB);
    end
  endtask

  task automatic model_next(input bit rst, input bit v, input bit pb, input logic [11:0] pot);
    int z;
    int tgt;
    if (rst) begin
      for (int k = 0; k < N; k++) begin g_m[k] = 0; on_m[k] = 0; end
      sel_m = 0; zs = 0; run = 1; chain_m = '0; led_m = '0;
      return;
    end
    if (v) chain_m = xs[N];
    for (int k = 0; k < N; k++) begin
      led_m[2*k]   = (sel_m == k + 1);
      led_m[2*k+1] = (sel_m == k + 1) && on_m[k];
    end
    if (v) begin
      for (int k = 0; k < N; k++) begin
        tgt = on_m[k] ? FULL : 0;
        if (XF) g_m[k] = g_m[k] + ((tgt > g_m[k]) ? 1 : (tgt < g_m[k]) ? -1 : 0);
        else    g_m[k] = tgt;
      end
    end
    if (pb && sel_m != 0) on_m[sel_m-1] = ~on_m[sel_m-1];
    // the zone has been seen on exactly S consecutive edges before this one
    if (run == S) sel_m = zs;
    z = (int'(pot) * (N + 1)) >> 12;
    if (z == zs) run = (run > S) ? run : run + 1;
    else begin zs = z; run = 1; end
  endtask

  task automatic cycle(input bit rst, input bit v, input bit pb, input logic [15:0] d, input logic [11:0] pot);
    logic [63:0] e_in;
    logic [3:0]  e_on;
    RESET = rst; VALID = v; pb_fall = pb; dry_in = d; sel_pot = pot;
    drive_fx();
    model_next(rst, v, pb, pot);
    @(posedge clk);
    @(negedge clk);
    drive_fx();
    #1;
    for (int k = 0; k < N; k++) begin
      e_in[k*16 +: 16] = xs[k];
      e_on[k] = on_m[k];
    end
    check("chain_out", 64'($unsigned(chain_out)), 64'(chain_m));
    check("fx_in", 64'(fx_in), e_in);
    check("fx_on", 64'(fx_on), 64'(e_on));
    check("sel", 64'(sel), 64'(sel_m));
    check("led", 64'(LED), 64'(led_m));
  endtask

  task automatic tick(input bit v, input bit pb);
    cycle(1'b0, v, pb, cur_dry, cur_pot);
  endtask

  task automatic valids(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic wait_sel(input int target);
    for (int i = 0; i < 2 * S && sel !== 3'(target); i++) tick(1'b0, 1'b0);
    check("sel_wait", 64'(sel), 64'(target));
  endtask

  initial begin
    int n;
    mode = 0;
    for (int k = 0; k < N; k++) begin g_m[k] = 0; on_m[k] = 0; end
    sel_m = 0; zs = 0; run = 1; chain_m = '0; led_m = '0;
    cur_dry = 16'h1234; cur_pot = 12'h000;
    RESET = 1'b1; VALID = 1'b0; pb_fall = 1'b0; dry_in = cur_dry; sel_pot = cur_pot;
    drive_fx();

    // Reset with VALID pulsing, then the first VALID passes dry straight through
    cycle(1'b1, 1'b1, 1'b0, cur_dry, cur_pot);
    cycle(1'b1, 1'b1, 1'b0, cur_dry, cur_pot);
    check("rst_chain", 64'($unsigned(chain_out)), 64'h0);
    check("rst_led", 64'(LED), 64'h0);
    check("rst_fx_on", 64'(fx_on), 64'h0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("first_valid", 64'($unsigned(chain_out)), 64'h1234);

    // Glitch to zone 2 shorter than the window, then hold zone 4
    cur_pot = 12'h999;
    for (int i = 0; i < 1000; i++) tick(1'b0, 1'b0);
    check("glitch_sel", 64'(sel), 64'h0);
    cur_pot = 12'hFFF;
    tick(1'b0, 1'b0);
    n = 0;
    while (sel !== 3'd4 && n < 2 * S) begin tick(1'b0, 1'b0); n++; end
    check("sel_latency", 64'(n), 64'(S));
    tick(1'b0, 1'b0);
    check("led_sel4", 64'(LED), 64'h40);

    // Crossfade effect 0 on
    cur_pot = 12'h400;
    wait_sel(1);
    cur_dry = 16'h1000;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    check("xf_first", 64'(fx_in[W +: W]), XF ? 64'h1080 : 64'h3000);
    valids(64);
    check("xf_done", 64'($unsigned(chain_out)), 64'h3000);
    check("xf_led", 64'(LED[1:0]), 64'h3);

    // Fade off fully, then reverse a partial fade
    tick(1'b0, 1'b1);
    valids(65);
    check("off_done", 64'($unsigned(chain_out)), 64'h1000);
    tick(1'b0, 1'b1);
    valids(20);
    check("mid_ramp", 64'(fx_in[W +: W]), XF ? 64'h1A00 : 64'h3000);
    tick(1'b0, 1'b1);
    valids(20);
    check("reversed", 64'(fx_in[W +: W]), 64'h1000);
    cur_pot = 12'h000;
    wait_sel(0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("sel0_ignore", 64'(fx_on), 64'h0);

    // Two stages on: +0x100 then x2
    mode = 1;
    cur_pot = 12'h400;
    wait_sel(1);
    tick(1'b0, 1'b1);
    cur_pot = 12'hA00;
    wait_sel(3);
    tick(1'b0, 1'b1);
    valids(66);
    check("two_on", 64'(fx_on), 64'h5);
    cur_dry = 16'h0300;
    tick(1'b1, 1'b0);
    check("chain_pos", 64'($unsigned(chain_out)), 64'h0800);
    cur_dry = 16'hF800;
    tick(1'b1, 1'b0);
    check("chain_neg", 64'($unsigned(chain_out)), 64'hF200);

    // Randomized traffic including mid-fade resets
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 799) == 0) cur_pot = 12'($urandom_range(0, 4095));
      cur_dry = 16'($urandom_range(0, 'h2000) - 'h1000);
      cycle($urandom_range(0, 2999) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0, cur_dry, cur_pot);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
